// File: rtl/tri_st_mult_seq_pkg.sv
// Shared constants and FSM encoding for the iterative radix-4 Booth multiply sequencer.
package tri_st_mult_seq_pkg;

  localparam int NDIG = 17;
  localparam int CNTW = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/tri_st_mult_boothrow.sv
// One Booth partial-product row: selects 0, x or 2x of the sign-extended multiplicand,
// one's-complemented when negative; the +1 of the two's complement leaves as o_hot_one.
module tri_st_mult_boothrow (
  input  logic [31:0] i_x,
  input  logic        i_sgn_adj,
  input  logic        i_s_neg,
  input  logic        i_s_x,
  input  logic        i_s_x2,
  output logic [33:0] o_q,
  output logic        o_hot_one
);

  logic [32:0] w_xe;
  logic [33:0] w_sel;

  assign w_xe = {i_sgn_adj, i_x};

  // top bit keeps 2x exact when the multiplicand is a full 32-bit unsigned value
  always_comb begin
    w_sel = '0;
    if (i_s_x) begin
      w_sel = {w_xe[32], w_xe};
    end else if (i_s_x2) begin
      w_sel = {w_xe, 1'b0};
    end
  end

  assign o_q       = i_s_neg ? ~w_sel : w_sel;
  assign o_hot_one = i_s_neg;

endmodule

// File: rtl/tri_st_mult_bthenc.sv
// Radix-4 Booth digit encoder: multiplier triplet (y2,y1,y0) to row selects.
module tri_st_mult_bthenc (
  input  logic [2:0] i_trip,
  output logic       o_s_neg,
  output logic       o_s_x,
  output logic       o_s_x2
);

  logic w_y2, w_y1, w_y0;

  assign {w_y2, w_y1, w_y0} = i_trip;

  assign o_s_x   = w_y1 ^ w_y0;
  assign o_s_x2  = (w_y2 & ~w_y1 & ~w_y0) | (~w_y2 & w_y1 & w_y0);
  // digit 111 is -0: keep it a plain zero row so no hot one is injected
  assign o_s_neg = w_y2 & ~(w_y1 & w_y0);

endmodule

// File: rtl/tri_st_mult_seq.sv
// Iterative 32x32->64 radix-4 Booth multiplier: one row reused over 17 cycles,
// valid/ready request in, valid/ready result out, kill flushes any operation.
module tri_st_mult_seq
  import tri_st_mult_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_sgn,
  input  logic [0:31] req_a,
  input  logic [0:31] req_b,
  input  logic        kill,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [0:63] out_prod,
  output logic        out_ovf
);

  state_t          r_state, w_state_next;
  logic [CNTW-1:0] r_cnt;
  logic [34:0]     r_mplr;
  logic [31:0]     r_a;
  logic            r_sadj, r_sgn;
  logic [34:0]     r_hi;
  logic [31:0]     r_lo;
  logic [63:0]     r_prod;
  logic            r_ovf;

  logic        w_accept, w_step, w_last, w_ext;
  logic [31:0] w_b;
  logic        w_s_neg, w_s_x, w_s_x2, w_hot;
  logic [33:0] w_q;
  logic [34:0] w_sum;
  logic [63:0] w_prod_final;
  logic [32:0] w_prod_top;
  logic        w_ovf_final;

  assign req_rdy  = ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_rdy)) & ~kill;
  assign w_accept = req_val & req_rdy;
  assign w_step   = (r_state == ST_BUSY) & ~kill;
  assign w_last   = (r_cnt == CNTW'(NDIG - 1));
  assign w_b      = req_b;
  assign w_ext    = req_sgn & w_b[31];

  tri_st_mult_bthenc u_enc (
    .i_trip  (r_mplr[2:0]),
    .o_s_neg (w_s_neg),
    .o_s_x   (w_s_x),
    .o_s_x2  (w_s_x2)
  );

  tri_st_mult_boothrow u_row (
    .i_x       (r_a),
    .i_sgn_adj (r_sadj),
    .i_s_neg   (w_s_neg),
    .i_s_x     (w_s_x),
    .i_s_x2    (w_s_x2),
    .o_q       (w_q),
    .o_hot_one (w_hot)
  );

  assign w_sum        = r_hi + {w_q[33], w_q} + {34'd0, w_hot};
  // the last digit is not shifted, so lo has received exactly 32 bits by then
  assign w_prod_final = {w_sum[31:0], r_lo};
  assign w_prod_top   = w_prod_final[63:31];
  assign w_ovf_final  = r_sgn & ~((&w_prod_top) | ~(|w_prod_top));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_BUSY;
      ST_BUSY: if (w_last) w_state_next = ST_DONE;
      ST_DONE: begin
        if (w_accept) w_state_next = ST_BUSY;
        else if (out_rdy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (kill) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_mplr <= '0;
      r_a    <= '0;
      r_sadj <= 1'b0;
      r_sgn  <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_prod <= '0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_a    <= req_a;
      r_sadj <= req_sgn & req_a[0];
      r_sgn  <= req_sgn;
      r_mplr <= {w_ext, w_ext, w_b, 1'b0};
    end else if (w_step) begin
      r_cnt  <= r_cnt + CNTW'(1);
      r_mplr <= {2'b00, r_mplr[34:2]};
      if (w_last) begin
        r_hi   <= w_sum;
        r_prod <= w_prod_final;
        r_ovf  <= w_ovf_final;
      end else begin
        r_hi <= {{2{w_sum[34]}}, w_sum[34:2]};
        r_lo <= {w_sum[1:0], r_lo[31:2]};
      end
    end
  end

  assign out_val  = (r_state == ST_DONE);
  assign out_prod = r_prod;
  assign out_ovf  = r_ovf;

endmodule

// File: tb/tb_tri_st_mult_seq.sv
// Directed and random checks of the Booth multiply sequencer: products, overflow,
// latency, kill, output hold, back-to-back accept and mid-operation reset.
module tb_tri_st_mult_seq;

  logic        clk = 1'b0;
  logic        rst, req_val, req_rdy, req_sgn, kill, out_val, out_rdy, out_ovf;
  logic [0:31] req_a, req_b;
  logic [0:63] out_prod;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tri_st_mult_seq dut (
    .clk      (clk),
    .rst      (rst),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_sgn  (req_sgn),
    .req_a    (req_a),
    .req_b    (req_b),
    .kill     (kill),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_prod (out_prod),
    .out_ovf  (out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a request in cycle 0; returns in cycle 1 with scrambled (ignored) inputs
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    req_val = 1'b1;
    req_sgn = sgn;
    req_a   = a;
    req_b   = b;
    #1;
    check("req_rdy_at_issue", req_rdy, 1);
    tick();
    req_val = 1'b0;
    req_sgn = ~sgn;
    req_a   = ~a;
    req_b   = 32'h5A5A5A5A;
  endtask

  // called in cycle 1; returns in the first cycle with out_val=1 (nothing consumed)
  task automatic wait_result(input string tag, input logic [63:0] exp_p, input logic exp_o,
                             input bit chk_lat);
    bit seen;
    int cyc;
    seen = 1'b0;
    cyc  = 1;
    if (out_val) seen = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      cyc++;
      if (out_val) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
    if (chk_lat) check({tag, "_lat"}, cyc, 18);
    check({tag, "_prod"}, out_prod, exp_p);
    check({tag, "_ovf"}, out_ovf, exp_o);
    $display("op %s: prod=0x%016h ovf=%0b cycle=%0d", tag, out_prod, out_ovf, cyc);
  endtask

  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_p, input logic exp_o);
    issue(sgn, a, b);
    wait_result(tag, exp_p, exp_o, 1'b1);
    tick();
    check({tag, "_consumed"}, out_val, 0);
  endtask

  logic [31:0] ra, rb;
  logic        rs, rovf;
  logic [63:0] rp;
  logic [63:0] held;
  int          nval;

  initial begin
    rst = 1'b1; req_val = 1'b0; req_sgn = 1'b0; req_a = '0; req_b = '0;
    kill = 1'b0; out_rdy = 1'b1;
    tick();
    tick();
    check("rst_req_rdy", req_rdy, 1);
    check("rst_out_val", out_val, 0);
    check("rst_out_prod", out_prod, 64'h0);
    check("rst_out_ovf", out_ovf, 0);
    rst = 1'b0;

    run_op("s_m1_m1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, 1'b0);
    run_op("u_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
    run_op("s_min_min", 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b1);
    run_op("s_7_m3", 1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1'b0);
    run_op("s_p2e31", 1'b1, 32'h00010000, 32'h00008000, 64'h0000000080000000, 1'b1);
    run_op("s_m2e31", 1'b1, 32'hFFFF0000, 32'h00008000, 64'hFFFFFFFF80000000, 1'b0);
    run_op("s_min_max", 1'b1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000, 1'b1);
    run_op("u_2e31_x2", 1'b0, 32'h80000000, 32'h00000002, 64'h0000000100000000, 1'b0);

    // kill in cycle 5 of an operation
    issue(1'b0, 32'd9, 32'd9);
    for (int k = 0; k < 4; k++) tick();
    kill = 1'b1;
    #1;
    check("kill_blocks_rdy", req_rdy, 0);
    tick();
    kill = 1'b0;
    #1;
    check("kill_rdy_c6", req_rdy, 1);
    nval = 0;
    for (int k = 0; k < 25; k++) begin
      if (out_val) nval++;
      tick();
    end
    check("kill_no_out_val", nval, 0);
    run_op("u_3_5", 1'b0, 32'd3, 32'd5, 64'h000000000000000F, 1'b0);

    // result held under backpressure, then back-to-back accept
    out_rdy = 1'b0;
    issue(1'b1, 32'h00000007, 32'hFFFFFFFD);
    wait_result("hold", 64'hFFFFFFFFFFFFFFEB, 1'b0, 1'b1);
    held = out_prod;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_val", out_val, 1);
      check("hold_prod", out_prod, held);
      check("hold_ovf", out_ovf, 0);
    end
    out_rdy = 1'b1;
    issue(1'b0, 32'h00010000, 32'h00010000);
    check("b2b_val_dropped", out_val, 0);
    wait_result("b2b", 64'h0000000100000000, 1'b0, 1'b1);
    tick();

    // synchronous reset in cycle 9 of an operation
    issue(1'b1, 32'h12345678, 32'h9ABCDEF0);
    for (int k = 0; k < 8; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_val", out_val, 0);
    check("mid_rst_rdy", req_rdy, 1);
    check("mid_rst_prod", out_prod, 64'h0);
    check("mid_rst_ovf", out_ovf, 0);
    nval = 0;
    for (int k = 0; k < 25; k++) begin
      if (out_val) nval++;
      tick();
    end
    check("mid_rst_no_val", nval, 0);

    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 10 == 0) ra = 32'h80000000;
      if (i % 10 == 5) rb = 32'hFFFFFFFF;
      if (rs) rp = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
      else    rp = {32'd0, ra} * {32'd0, rb};
      rovf = rs & ~((&rp[63:31]) | ~(|rp[63:31]));
      run_op($sformatf("rnd%0d_s%0d_%08h_%08h", i, rs, ra, rb), rs, ra, rb, rp, rovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
